// File: rtl/endec_pkg.sv
// Shared constants and types for the encoder/decoder byte-stream path.
// MAX_LEN of the arbiter and the detector codeword length share CODEWORD_LEN.
package endec_pkg;

    localparam int AXIS_DATA_W  = 8;
    localparam int CODEWORD_LEN = 255;
    localparam int LEN_CNT_W    = 8;

    typedef enum logic {
        ARB_IDLE = 1'b0,
        ARB_LOCK = 1'b1
    } arb_state_e;

    // Next channel index in round-robin order, wrapping at num_ch.
    function automatic int wrap_inc(input int idx, input int num_ch);
        return (idx + 1 >= num_ch) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/codeword_arbiter_rr_pick.sv
// Combinational round-robin select: first requester at or after ptr_i,
// wrapping modulo NUM_CH.
module rr_pick #(
    parameter int NUM_CH = 4,
    parameter int CH_W   = 2
) (
    input  logic [NUM_CH-1:0] req_i,
    input  logic [CH_W-1:0]   ptr_i,
    output logic [CH_W-1:0]   idx_o,
    output logic              found_o
);

    logic [2*NUM_CH-1:0] req_dbl;
    logic [2*NUM_CH-1:0] req_shift;
    logic [NUM_CH-1:0]   req_rot;
    logic [CH_W:0]       idx_sum;

    // Rotate so that bit 0 is the pointer's channel, then take the lowest set bit.
    always_comb begin
        req_dbl   = {req_i, req_i};
        req_shift = req_dbl >> ptr_i;
        req_rot   = req_shift[NUM_CH-1:0];
        idx_sum   = '0;
        idx_o     = '0;
        found_o   = 1'b0;
        for (int off = 0; off < NUM_CH; off++) begin
            if (!found_o && req_rot[off]) begin
                found_o = 1'b1;
                idx_sum = {1'b0, ptr_i} + (CH_W+1)'(off);
                if (idx_sum >= (CH_W+1)'(NUM_CH)) begin
                    idx_sum = idx_sum - (CH_W+1)'(NUM_CH);
                end
                idx_o = idx_sum[CH_W-1:0];
            end
        end
    end

endmodule

// File: rtl/codeword_arbiter.sv
// Round-robin codeword arbiter: shares one registered AXI-Stream byte output
// among NUM_CH channels, holding each grant for a whole codeword.
module codeword_arbiter
    import endec_pkg::*;
#(
    parameter int NUM_CH  = 4,
    parameter int CH_W    = 2,
    parameter int MAX_LEN = CODEWORD_LEN
) (
    input  logic                          core_clk,
    input  logic                          rst,
    input  logic [AXIS_DATA_W*NUM_CH-1:0] s_axis_tdata,
    input  logic [NUM_CH-1:0]             s_axis_tvalid,
    input  logic [NUM_CH-1:0]             s_axis_tlast,
    output logic [NUM_CH-1:0]             s_axis_tready,
    output logic [AXIS_DATA_W-1:0]        m_axis_output_tdata,
    output logic                          m_axis_output_tvalid,
    output logic                          m_axis_output_tlast,
    output logic [CH_W-1:0]               m_axis_output_tid,
    input  logic                          m_axis_output_tready,
    output logic [NUM_CH-1:0]             grant_o,
    output logic                          trunc_o
);

    arb_state_e             state_q, state_d;
    logic [CH_W-1:0]        rr_ptr_q, rr_ptr_d;
    logic [CH_W-1:0]        grant_q, grant_d;
    logic [LEN_CNT_W-1:0]   len_cnt_q, len_cnt_d;
    logic [AXIS_DATA_W-1:0] out_data_q, out_data_d;
    logic                   out_valid_q, out_valid_d;
    logic                   out_last_q, out_last_d;
    logic [CH_W-1:0]        out_tid_q, out_tid_d;
    logic                   trunc_q, trunc_d;

    logic [AXIS_DATA_W-1:0] sel_data;
    logic                   sel_valid;
    logic                   sel_last;
    logic                   out_free;
    logic                   len_hit;
    logic                   beat_last;
    logic                   accept;
    logic [CH_W-1:0]        pick_idx;
    logic                   pick_found;

    rr_pick #(
        .NUM_CH (NUM_CH),
        .CH_W   (CH_W)
    ) u_rr_pick (
        .req_i   (s_axis_tvalid),
        .ptr_i   (rr_ptr_q),
        .idx_o   (pick_idx),
        .found_o (pick_found)
    );

    always_comb begin
        sel_data  = '0;
        sel_valid = 1'b0;
        sel_last  = 1'b0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (grant_q == CH_W'(c)) begin
                sel_data  = s_axis_tdata[c*AXIS_DATA_W +: AXIS_DATA_W];
                sel_valid = s_axis_tvalid[c];
                sel_last  = s_axis_tlast[c];
            end
        end
    end

    // The output register is free when empty or being drained this cycle.
    assign out_free  = !out_valid_q || m_axis_output_tready;
    assign len_hit   = (len_cnt_q == LEN_CNT_W'(MAX_LEN - 1));
    assign beat_last = sel_last || len_hit;

    always_ff @(posedge core_clk or posedge rst) begin
        if (rst) begin
            state_q <= ARB_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ARB_IDLE: if (pick_found) state_d = ARB_LOCK;
            ARB_LOCK: if (accept && beat_last) state_d = ARB_IDLE;
            default:  state_d = ARB_IDLE;
        endcase
    end

    always_comb begin
        s_axis_tready = '0;
        grant_o       = '0;
        accept        = 1'b0;
        if (state_q == ARB_LOCK) begin
            for (int c = 0; c < NUM_CH; c++) begin
                if (grant_q == CH_W'(c)) begin
                    s_axis_tready[c] = out_free;
                    grant_o[c]       = 1'b1;
                end
            end
            accept = sel_valid && out_free;
        end
    end

    always_comb begin
        grant_d     = grant_q;
        rr_ptr_d    = rr_ptr_q;
        len_cnt_d   = len_cnt_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        out_last_d  = out_last_q;
        out_tid_d   = out_tid_q;
        trunc_d     = 1'b0;

        if (state_q == ARB_IDLE && pick_found) begin
            grant_d   = pick_idx;
            len_cnt_d = '0;
        end

        if (accept) begin
            out_data_d  = sel_data;
            out_tid_d   = grant_q;
            out_last_d  = beat_last;
            out_valid_d = 1'b1;
            len_cnt_d   = len_cnt_q + 1'b1;
            trunc_d     = len_hit && !sel_last;
            // A forced tlast ends the codeword exactly like a real one.
            if (beat_last) begin
                grant_d   = '0;
                rr_ptr_d  = CH_W'(wrap_inc(int'(grant_q), NUM_CH));
                len_cnt_d = '0;
            end
        end else if (m_axis_output_tready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge core_clk or posedge rst) begin
        if (rst) begin
            rr_ptr_q    <= '0;
            grant_q     <= '0;
            len_cnt_q   <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            out_tid_q   <= '0;
            trunc_q     <= 1'b0;
        end else begin
            rr_ptr_q    <= rr_ptr_d;
            grant_q     <= grant_d;
            len_cnt_q   <= len_cnt_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
            out_tid_q   <= out_tid_d;
            trunc_q     <= trunc_d;
        end
    end

    assign m_axis_output_tdata  = out_data_q;
    assign m_axis_output_tvalid = out_valid_q;
    assign m_axis_output_tlast  = out_last_q;
    assign m_axis_output_tid    = out_tid_q;
    assign trunc_o              = trunc_q;

endmodule

// File: tb/tb_codeword_arbiter.sv
// Self-checking bench for codeword_arbiter: per-channel byte queues feed the
// inputs, a queue-based scoreboard checks order, codeword integrity and tlast.
module tb_codeword_arbiter;

    logic        core_clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] s_tdata = '0;
    logic [3:0]  s_tvalid = '0;
    logic [3:0]  s_tlast = '0;
    logic        m_tready = 1'b0;

    logic [3:0] a_s_tready, b_s_tready, obs_s_tready;
    logic [7:0] a_tdata, b_tdata, obs_tdata;
    logic       a_tvalid, b_tvalid, obs_tvalid;
    logic       a_tlast, b_tlast, obs_tlast;
    logic [1:0] a_tid, b_tid, obs_tid;
    logic [3:0] a_grant, b_grant, obs_grant;
    logic       a_trunc, b_trunc, obs_trunc;

    bit sel = 1'b0;

    always #5 core_clk = ~core_clk;

    codeword_arbiter #(.NUM_CH(4), .CH_W(2), .MAX_LEN(255)) dut_full (
        .core_clk(core_clk), .rst(rst),
        .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid), .s_axis_tlast(s_tlast),
        .s_axis_tready(a_s_tready),
        .m_axis_output_tdata(a_tdata), .m_axis_output_tvalid(a_tvalid),
        .m_axis_output_tlast(a_tlast), .m_axis_output_tid(a_tid),
        .m_axis_output_tready(m_tready),
        .grant_o(a_grant), .trunc_o(a_trunc)
    );

    codeword_arbiter #(.NUM_CH(4), .CH_W(2), .MAX_LEN(8)) dut_short (
        .core_clk(core_clk), .rst(rst),
        .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid), .s_axis_tlast(s_tlast),
        .s_axis_tready(b_s_tready),
        .m_axis_output_tdata(b_tdata), .m_axis_output_tvalid(b_tvalid),
        .m_axis_output_tlast(b_tlast), .m_axis_output_tid(b_tid),
        .m_axis_output_tready(m_tready),
        .grant_o(b_grant), .trunc_o(b_trunc)
    );

    assign obs_s_tready = sel ? b_s_tready : a_s_tready;
    assign obs_tdata    = sel ? b_tdata    : a_tdata;
    assign obs_tvalid   = sel ? b_tvalid   : a_tvalid;
    assign obs_tlast    = sel ? b_tlast    : a_tlast;
    assign obs_tid      = sel ? b_tid      : a_tid;
    assign obs_grant    = sel ? b_grant    : a_grant;
    assign obs_trunc    = sel ? b_trunc    : a_trunc;

    int checks = 0;
    int errors = 0;
    int max_len = 255;
    int cycle;
    int gap_pct = 100;
    int ready_mode = 0;

    logic [8:0] ch_q [4][$];
    logic [8:0] sent_q [4][$];
    bit pres [4];
    bit pause [4];

    int cur_len, cur_tid, forced_total, trunc_total, held_cnt;
    int first_in_cyc, first_out_cyc;
    int log_tid [$];
    int log_data [$];
    int log_last [$];
    int log_cyc [$];
    bit prev_held;
    logic [7:0] held_data;
    logic       held_last;
    logic [1:0] held_tid;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic checkIdleOutputs(input string tag);
        checkOutput({tag, "_tvalid"}, 32'(obs_tvalid), 0);
        checkOutput({tag, "_tdata"}, 32'(obs_tdata), 0);
        checkOutput({tag, "_tlast"}, 32'(obs_tlast), 0);
        checkOutput({tag, "_tid"}, 32'(obs_tid), 0);
        checkOutput({tag, "_grant"}, 32'(obs_grant), 0);
        checkOutput({tag, "_trunc"}, 32'(obs_trunc), 0);
        checkOutput({tag, "_s_tready"}, 32'(obs_s_tready), 0);
    endtask

    task automatic applyReset(input bit use_short);
        rst = 1'b1;
        sel = use_short;
        max_len = use_short ? 8 : 255;
        s_tvalid = '0;
        s_tlast = '0;
        s_tdata = '0;
        m_tready = 1'b0;
        for (int c = 0; c < 4; c++) begin
            ch_q[c].delete();
            sent_q[c].delete();
            pres[c] = 1'b0;
            pause[c] = 1'b0;
        end
        cur_len = 0; cur_tid = 0; forced_total = 0; trunc_total = 0; held_cnt = 0;
        first_in_cyc = -1; first_out_cyc = -1; cycle = 0; prev_held = 1'b0;
        log_tid.delete(); log_data.delete(); log_last.delete(); log_cyc.delete();
        repeat (2) @(posedge core_clk);
        #1;
        checkIdleOutputs("reset");
        rst = 1'b0;
    endtask

    task automatic pushCodeword(input int c, input int len, input bit rnd, input int base);
        logic [7:0] d;
        for (int i = 0; i < len; i++) begin
            d = rnd ? 8'($urandom_range(255)) : 8'((base + i) & 255);
            ch_q[c].push_back({(i == len - 1), d});
        end
    endtask

    // One clock cycle: drive at posedge+1, evaluate handshakes at negedge.
    task automatic applyStimulus();
        int t;
        logic [8:0] e;
        bit fl;
        for (int c = 0; c < 4; c++) begin
            if (!pres[c] && ch_q[c].size() != 0 && !pause[c] && $urandom_range(99) < gap_pct) begin
                pres[c] = 1'b1;
                e = ch_q[c][0];
                s_tdata[c*8 +: 8] = e[7:0];
                s_tlast[c] = e[8];
                if (first_in_cyc < 0) first_in_cyc = cycle;
            end
            s_tvalid[c] = pres[c];
        end
        case (ready_mode)
            0: m_tready = 1'b1;
            1: m_tready = 1'($urandom_range(1));
            default: m_tready = (cycle % 4 == 0) || (cycle % 4 == 3);
        endcase

        @(negedge core_clk);
        checkOutput("ready_onehot", 32'($countones(obs_s_tready) <= 1), 1);
        checkOutput("ready_in_grant", 32'(obs_s_tready & ~obs_grant), 0);
        if (prev_held) begin
            checkOutput("hold_valid", 32'(obs_tvalid), 1);
            checkOutput("hold_data", 32'(obs_tdata), 32'(held_data));
            checkOutput("hold_tid", 32'(obs_tid), 32'(held_tid));
            checkOutput("hold_last", 32'(obs_tlast), 32'(held_last));
        end
        if (obs_tvalid && !m_tready) begin
            held_cnt++;
            checkOutput("ready_when_held", 32'(obs_s_tready), 0);
        end
        prev_held = obs_tvalid && !m_tready;
        held_data = obs_tdata; held_tid = obs_tid; held_last = obs_tlast;
        if (obs_tvalid && first_out_cyc < 0) first_out_cyc = cycle;

        if (obs_tvalid && m_tready) begin
            t = int'(obs_tid);
            checkOutput("beat_expected", 32'(sent_q[t].size() != 0), 1);
            if (sent_q[t].size() != 0) begin
                e = sent_q[t].pop_front();
                fl = !e[8] && (cur_len + 1 == max_len);
                checkOutput("out_data", 32'(obs_tdata), 32'(e[7:0]));
                checkOutput("out_last", 32'(obs_tlast), 32'(e[8] | fl));
                if (cur_len > 0) checkOutput("cw_tid", t, cur_tid);
                if (fl) forced_total++;
                cur_tid = t;
                cur_len = (e[8] || fl) ? 0 : cur_len + 1;
            end
            log_tid.push_back(t);
            log_data.push_back(int'(obs_tdata));
            log_last.push_back(int'(obs_tlast));
            log_cyc.push_back(cycle);
        end
        for (int c = 0; c < 4; c++) begin
            if (s_tvalid[c] && obs_s_tready[c]) begin
                sent_q[c].push_back(ch_q[c].pop_front());
                pres[c] = 1'b0;
            end
        end

        @(posedge core_clk);
        #1;
        if (obs_trunc) trunc_total++;
        checkOutput("trunc_align", 32'(obs_trunc & ~(obs_tvalid & obs_tlast)), 0);
        cycle++;
    endtask

    function automatic bit busy();
        bit b = obs_tvalid;
        for (int c = 0; c < 4; c++) begin
            if (ch_q[c].size() != 0 || sent_q[c].size() != 0 || pres[c]) b = 1'b1;
        end
        return b;
    endfunction

    task automatic drain(input string tag, input int budget);
        int n = 0;
        int left = 0;
        while (busy() && n < budget) begin
            applyStimulus();
            n++;
        end
        checkOutput({tag, "_drain_in_time"}, 32'(n < budget), 1);
        for (int c = 0; c < 4; c++) left += ch_q[c].size() + sent_q[c].size();
        checkOutput({tag, "_no_loss"}, left, 0);
        checkOutput({tag, "_trunc_count"}, trunc_total, forced_total);
    endtask

    initial begin
        int k;
        int n;

        // Single channel, full-length codeword
        applyReset(1'b0);
        gap_pct = 100; ready_mode = 0;
        pushCodeword(2, 255, 1'b0, 0);
        drain("single", 400);
        checkOutput("single_beats", log_tid.size(), 255);
        for (int i = 0; i < log_tid.size(); i++) begin
            checkOutput("single_tid", log_tid[i], 2);
            checkOutput("single_data", log_data[i], i);
            checkOutput("single_last", log_last[i], 32'(i == 254));
        end
        checkOutput("single_latency", first_out_cyc - first_in_cyc, 2);
        if (log_cyc.size() == 255) checkOutput("single_throughput", log_cyc[254] - log_cyc[0], 254);
        checkOutput("single_trunc", trunc_total, 0);

        // Round-robin fairness, all channels requesting
        applyReset(1'b0);
        for (int r = 0; r < 2; r++)
            for (int c = 0; c < 4; c++) pushCodeword(c, 3, 1'b0, 16 * c + 4 * r);
        drain("rr", 200);
        checkOutput("rr_beats", log_tid.size(), 24);
        k = 0;
        for (int i = 0; i < log_tid.size(); i++) begin
            if (i == 0 || log_last[i-1] != 0) begin
                checkOutput("rr_order", log_tid[i], k % 4);
                if (i > 0) checkOutput("rr_gap", log_cyc[i] - log_cyc[i-1], 2);
                k++;
            end
        end

        // Backpressure with ready pattern 1,0,0,1
        applyReset(1'b0);
        ready_mode = 2;
        pushCodeword(1, 20, 1'b1, 0);
        drain("bp", 300);
        checkOutput("bp_beats", log_tid.size(), 20);
        checkOutput("bp_held_seen", 32'(held_cnt > 0), 1);

        // Length guard on the MAX_LEN=8 instance
        applyReset(1'b1);
        ready_mode = 0;
        pushCodeword(0, 10, 1'b0, 8'h40);
        drain("guard", 100);
        checkOutput("guard_beats", log_tid.size(), 10);
        if (log_tid.size() == 10) begin
            checkOutput("guard_last8", log_last[7], 1);
            checkOutput("guard_last7", log_last[6], 0);
            checkOutput("guard_last10", log_last[9], 1);
            checkOutput("guard_rearb_gap", log_cyc[8] - log_cyc[7], 2);
            checkOutput("guard_byte9", log_data[8], 8'h48);
        end
        checkOutput("guard_trunc_pulses", trunc_total, 1);

        // Reset in the middle of a ch3 codeword
        applyReset(1'b0);
        pushCodeword(3, 200, 1'b0, 0);
        n = 0;
        while (log_tid.size() < 100 && n < 300) begin
            applyStimulus();
            n++;
        end
        checkOutput("midrst_reached", 32'(n < 300), 1);
        checkOutput("midrst_busy", 32'(obs_tvalid), 1);
        #2 rst = 1'b1;
        #1;
        checkIdleOutputs("midrst");
        applyReset(1'b0);
        pushCodeword(3, 2, 1'b0, 8'h30);
        pushCodeword(0, 2, 1'b0, 8'h00);
        drain("after_rst", 50);
        checkOutput("after_rst_beats", log_tid.size(), 4);
        if (log_tid.size() != 0) checkOutput("after_rst_first", log_tid[0], 0);

        // Sparse input: granted ch1 pauses while ch0 waits
        applyReset(1'b0);
        pushCodeword(1, 6, 1'b0, 8'h10);
        pushCodeword(0, 3, 1'b0, 8'h00);
        pause[0] = 1'b1;
        repeat (3) applyStimulus();
        pause[1] = 1'b1;
        pause[0] = 1'b0;
        for (int i = 0; i < 5; i++) begin
            applyStimulus();
            checkOutput("sparse_grant", 32'(obs_grant), 32'h2);
        end
        pause[1] = 1'b0;
        drain("sparse", 100);
        checkOutput("sparse_beats", log_tid.size(), 9);
        for (int i = 0; i < log_tid.size(); i++)
            checkOutput("sparse_order", log_tid[i], (i < 6) ? 1 : 0);

        // Random traffic on the short instance
        applyReset(1'b1);
        gap_pct = 60; ready_mode = 1;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++) pushCodeword(c, $urandom_range(1, 14), 1'b1, 0);
        drain("random", 4000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
